// File: rtl/ps2_pkg.sv
// Purpose: shared constants and the key event type for the PS/2 keyboard receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
  localparam int unsigned PS2_FRAME_LEN    = 11;

  // One buffered key event: prefixes folded into flags, scan code kept raw.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Purpose: synchronous event FIFO with wrap-bit pointers and a combinational head output.
// Latency: push visible at the head one cycle after the write; pop advances the head next cycle.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
//
// Ports: clk, clrn (async active-low reset); push_vld/push_dat write side;
//        pop_vld read side; head_dat oldest entry; full/empty status.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop_vld & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push_vld & (~full | do_pop);
  assign head_dat = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// Purpose: PS/2 keyboard receiver: synchronise pins, deserialise and check frames, fold prefixes into key events, buffer them.
// Latency: stop-bit sample at T -> event registered T+1 -> ready/key_* at T+2; pop on nextdata_n fall visible next cycle.
// Backpressure: none toward the keyboard; events arriving while the FIFO is full are dropped and set sticky overflow.
//
// Ports: clk, clrn (async active-low reset); ps2_clk/ps2_data raw pins;
//        nextdata_n active-low read strobe; ready + key_code/key_break/key_ext head event;
//        overflow sticky drop flag; frame_err one-cycle error pulse; keystroke press counter.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             nextdata_n,
  output logic             ready,
  output logic [7:0]       key_code,
  output logic             key_break,
  output logic             key_ext,
  output logic             overflow,
  output logic             frame_err,
  output logic [CNT_W-1:0] keystroke
);

  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_LEN - 1);

  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       bits_q, bits_d;        // start, d[7:0], parity once 10 bits are in
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             ext_f_q, ext_f_d;
  logic             brk_f_q, brk_f_d;
  logic             held_vld_q, held_vld_d;
  logic             held_ext_q, held_ext_d;
  logic [7:0]       held_code_q, held_code_d;
  logic [CNT_W-1:0] keystroke_q, keystroke_d;
  logic             frame_err_q, frame_err_d;
  logic             push_vld_q, push_vld_d;
  ps2_event_t       push_dat_q, push_dat_d;
  logic             overflow_q, overflow_d;
  logic             nd_q, nd_d;

  logic             sample;
  logic             data_s;
  logic             frame_good;
  logic [7:0]       rx_byte;
  logic             held_match;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_vld;
  ps2_event_t       head_evt;

  assign sample     = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_s     = dat_sync_q[1];
  assign rx_byte    = bits_q[8:1];
  // Stop bit is the live sample; the other ten bits are already shifted in.
  assign frame_good = ~bits_q[0] & (^bits_q[9:1]) & data_s;
  assign held_match = held_vld_q && (held_ext_q == ext_f_q) && (held_code_q == rx_byte);

  assign ready   = ~fifo_empty;
  assign pop_vld = nd_q & ~nextdata_n & ready;

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d  = {dat_sync_q[0], ps2_data};
    bit_cnt_d   = bit_cnt_q;
    bits_d      = bits_q;
    tmo_d       = tmo_q;
    ext_f_d     = ext_f_q;
    brk_f_d     = brk_f_q;
    held_vld_d  = held_vld_q;
    held_ext_d  = held_ext_q;
    held_code_d = held_code_q;
    keystroke_d = keystroke_q;
    frame_err_d = 1'b0;
    push_vld_d  = 1'b0;
    push_dat_d  = push_dat_q;
    nd_d        = nextdata_n;
    // Only a push that neither fits nor is matched by a pop is lost.
    overflow_d  = overflow_q | (push_vld_q & fifo_full & ~pop_vld);

    if (sample) begin
      tmo_d = '0;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        if (frame_good) begin
          if (rx_byte == PS2_EXT_PREFIX) begin
            ext_f_d = 1'b1;
          end else if (rx_byte == PS2_BREAK_PREFIX) begin
            brk_f_d = 1'b1;
          end else begin
            push_vld_d = 1'b1;
            push_dat_d = '{ext: ext_f_q, brk: brk_f_q, code: rx_byte};
            ext_f_d    = 1'b0;
            brk_f_d    = 1'b0;
            if (!brk_f_q) begin
              // A repeat of the held key is typematic, not a new press.
              if (!held_match) begin
                keystroke_d = keystroke_q + CNT_W'(1);
                held_vld_d  = 1'b1;
                held_ext_d  = ext_f_q;
                held_code_d = rx_byte;
              end
            end else if (held_match) begin
              held_vld_d = 1'b0;
            end
          end
        end else begin
          frame_err_d = 1'b1;
          ext_f_d     = 1'b0;
          brk_f_d     = 1'b0;
        end
      end else begin
        bits_d    = {data_s, bits_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d   = '0;
        tmo_d       = '0;
        frame_err_d = 1'b1;
        ext_f_d     = 1'b0;
        brk_f_d     = 1'b0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 3'b111;
      dat_sync_q  <= 2'b11;
      bit_cnt_q   <= '0;
      bits_q      <= '0;
      tmo_q       <= '0;
      ext_f_q     <= 1'b0;
      brk_f_q     <= 1'b0;
      held_vld_q  <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= '0;
      keystroke_q <= '0;
      frame_err_q <= 1'b0;
      push_vld_q  <= 1'b0;
      push_dat_q  <= '0;
      overflow_q  <= 1'b0;
      nd_q        <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      bits_q      <= bits_d;
      tmo_q       <= tmo_d;
      ext_f_q     <= ext_f_d;
      brk_f_q     <= brk_f_d;
      held_vld_q  <= held_vld_d;
      held_ext_q  <= held_ext_d;
      held_code_q <= held_code_d;
      keystroke_q <= keystroke_d;
      frame_err_q <= frame_err_d;
      push_vld_q  <= push_vld_d;
      push_dat_q  <= push_dat_d;
      overflow_q  <= overflow_d;
      nd_q        <= nd_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk      (clk),
    .clrn     (clrn),
    .push_vld (push_vld_q),
    .push_dat (push_dat_q),
    .pop_vld  (pop_vld),
    .head_dat (head_evt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    key_code  = 8'h00;
    key_break = 1'b0;
    key_ext   = 1'b0;
    if (ready) begin
      key_code  = head_evt.code;
      key_break = head_evt.brk;
      key_ext   = head_evt.ext;
    end
  end

  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign keystroke = keystroke_q;

endmodule
